frog_controller: RTL

FROG_CONTROLLER -- requirements
Module: frog_controller

---
 rtl/frogger_pkg.sv | 21 ++
 rtl/btn_edge.sv | 28 ++
 rtl/frog_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/frogger_pkg.sv
// Shared types and board constants for the frogger game controller.
package frogger_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StHit,
    StWin,
    StOver
  } state_e;

  localparam logic [2:0]  START_ROW = 3'd0;
  localparam logic [2:0]  GOAL_ROW  = 3'd7;
  localparam logic [15:0] START_COL = 16'h0100;

  // Rows that carry traffic; every other row is safe.
  localparam logic [2:0] LANE_ROW_1 = 3'd1;
  localparam logic [2:0] LANE_ROW_3 = 3'd3;
  localparam logic [2:0] LANE_ROW_5 = 3'd5;
  localparam logic [2:0] LANE_ROW_6 = 3'd6;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronised button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q, prev_d;

  // Next previous-level value is simply the current level.
  always_comb begin
    prev_d = level_i;
  end

  // Reset loads the live level: the register clears when the button is up, and a
  // button held through reset deassertion is treated as already seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= level_i;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/frog_controller.sv
// Frog position, lives and game-end controller for the frogger board.
module frog_controller
  import frogger_pkg::*;
#(
  parameter int unsigned LIVES    = 3,
  parameter int unsigned HIT_HOLD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic [15:0] car1,
  input  logic [15:0] car3,
  input  logic [15:0] car5,
  input  logic [15:0] car6,
  output integer      displayRow,
  output logic [15:0] displayPattern,
  output logic [1:0]  lives,
  output logic        win,
  output logic        lose
);

  logic [3:0] pulses;  // {up, down, left, right}

  btn_edge u_edge_up (
    .clk     (clk),
    .reset   (reset),
    .level_i (up),
    .pulse_o (pulses[3])
  );

  btn_edge u_edge_down (
    .clk     (clk),
    .reset   (reset),
    .level_i (down),
    .pulse_o (pulses[2])
  );

  btn_edge u_edge_left (
    .clk     (clk),
    .reset   (reset),
    .level_i (left),
    .pulse_o (pulses[1])
  );

  btn_edge u_edge_right (
    .clk     (clk),
    .reset   (reset),
    .level_i (right),
    .pulse_o (pulses[0])
  );

  state_e      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] pat_q, pat_d;
  logic [1:0]  lives_q, lives_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic [3:0]  hold_q, hold_d;

  logic [15:0] lane_cars;
  logic        collide;
  logic        single_pulse;

  // Car vector of the row the frog currently occupies; safe rows see no cars.
  always_comb begin
    lane_cars = 16'h0000;
    unique case (row_q)
      LANE_ROW_1: lane_cars = car1;
      LANE_ROW_3: lane_cars = car3;
      LANE_ROW_5: lane_cars = car5;
      LANE_ROW_6: lane_cars = car6;
      default:    lane_cars = 16'h0000;
    endcase
  end

  assign collide      = |(lane_cars & pat_q);
  assign single_pulse = (pulses != 4'b0000) && ((pulses & (pulses - 4'd1)) == 4'b0000);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StPlay;
      row_q   <= START_ROW;
      pat_q   <= START_COL;
      lives_q <= 2'(LIVES);
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      lives_q <= lives_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: collision beats movement; only a lone pulse moves the frog.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pat_d   = pat_q;
    lives_d = lives_q;
    win_d   = win_q;
    lose_d  = lose_q;
    hold_d  = hold_q;
    unique case (state_q)
      StPlay: begin
        if (collide) begin
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            hold_d  = 4'(HIT_HOLD);
            state_d = StHit;
          end else begin
            lives_d = 2'd0;
            lose_d  = 1'b1;
            state_d = StOver;
          end
        end else if (single_pulse) begin
          unique case (pulses)
            4'b1000: begin
              row_d = row_q + 3'd1;
              if (row_q == GOAL_ROW - 3'd1) begin
                win_d   = 1'b1;
                state_d = StWin;
              end
            end
            4'b0100: if (row_q != START_ROW) row_d = row_q - 3'd1;
            4'b0010: if (!pat_q[15]) pat_d = pat_q << 1;
            4'b0001: if (!pat_q[0]) pat_d = pat_q >> 1;
            default: ;
          endcase
        end
      end
      StHit: begin
        if (hold_q <= 4'd1) begin
          hold_d  = 4'd0;
          row_d   = START_ROW;
          pat_d   = START_COL;
          state_d = StPlay;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      StWin, StOver: ;
      default: state_d = StPlay;
    endcase
  end

  // Outputs come straight from the registers.
  always_comb begin
    displayRow     = {29'd0, row_q};
    displayPattern = pat_q;
    lives          = lives_q;
    win            = win_q;
    lose           = lose_q;
  end

endmodule
